// File: rtl/prt_scaler_vout.sv
// Scaler output stage: turns qualified VS/DE pixel samples into a tagged {SOF,EOL,RGB}
// stream through a one-word hold register and a first-word-fall-through FIFO.
module prt_scaler_vout #(
  parameter int P_PPC        = 4,
  parameter int P_BPC        = 8,
  parameter int P_FIFO_DEPTH = 16
) (
  input  logic                       CLK_IN,
  input  logic                       RST_IN,
  input  logic                       CKE_IN,
  input  logic                       VS_IN,
  input  logic                       HS_IN,
  input  logic                       DE_IN,
  input  logic [P_PPC*P_BPC-1:0]     R_IN,
  input  logic [P_PPC*P_BPC-1:0]     G_IN,
  input  logic [P_PPC*P_BPC-1:0]     B_IN,
  output logic [3*P_PPC*P_BPC-1:0]   M_DAT_OUT,
  output logic                       M_SOF_OUT,
  output logic                       M_EOL_OUT,
  output logic                       M_VLD_OUT,
  input  logic                       M_RDY_IN,
  output logic                       OVF_OUT,
  output logic [15:0]                LINES_OUT
);

  localparam int DW = 3 * P_PPC * P_BPC;
  localparam int WW = DW + 2;
  localparam int AW = $clog2(P_FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DROP} state_t;

  state_t          state, state_nxt;
  logic            vs_prev;
  logic            vs_rise;
  logic            sof_armed;
  logic            hold_vld;
  logic            hold_sof;
  logic [DW-1:0]   hold_dat;
  logic            wr_pend;
  logic [WW-1:0]   wr_word;
  logic [15:0]     line_cnt;

  logic [WW-1:0]   mem [P_FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            fifo_full, rd_en, wr_req, wr_en, ovf_evt;

  // Line boundaries come from DE alone; HS is deliberately ignored.
  logic unused_hs;
  assign unused_hs = HS_IN;

  assign vs_rise   = CKE_IN & VS_IN & ~vs_prev;
  assign fifo_full = (count == CW'(P_FIFO_DEPTH));
  assign M_VLD_OUT = (count != '0);
  assign rd_en     = M_VLD_OUT & M_RDY_IN;
  assign wr_req    = wr_pend & (state != S_DROP);
  assign wr_en     = wr_req & (~fifo_full | rd_en);
  assign ovf_evt   = wr_req & fifo_full & ~rd_en;

  assign {M_SOF_OUT, M_EOL_OUT, M_DAT_OUT} = M_VLD_OUT ? mem[rd_ptr] : '0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (vs_rise) state_nxt = S_ACTIVE;
      S_ACTIVE: if (ovf_evt) state_nxt = S_DROP;
      S_DROP:   if (vs_rise) state_nxt = S_ACTIVE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Word assembly: a word is only resolved (EOL or not) when the next qualified sample arrives.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      vs_prev   <= 1'b0;
      sof_armed <= 1'b0;
      hold_vld  <= 1'b0;
      hold_sof  <= 1'b0;
      hold_dat  <= '0;
      wr_pend   <= 1'b0;
      wr_word   <= '0;
      line_cnt  <= '0;
      LINES_OUT <= '0;
    end else begin
      wr_pend <= 1'b0;
      if (CKE_IN) begin
        vs_prev <= VS_IN;
        if (vs_rise) begin
          sof_armed <= 1'b1;
          hold_vld  <= 1'b0;
          line_cnt  <= '0;
          if (state != S_IDLE) LINES_OUT <= line_cnt;
        end else if (state == S_ACTIVE) begin
          if (DE_IN) begin
            hold_dat  <= {R_IN, G_IN, B_IN};
            hold_sof  <= sof_armed;
            hold_vld  <= 1'b1;
            sof_armed <= 1'b0;
            wr_pend   <= hold_vld;
            wr_word   <= {hold_sof, 1'b0, hold_dat};
          end else if (hold_vld) begin
            hold_vld <= 1'b0;
            wr_pend  <= 1'b1;
            wr_word  <= {hold_sof, 1'b1, hold_dat};
            if (line_cnt != 16'hFFFF) line_cnt <= line_cnt + 16'd1;
          end
        end
      end
    end
  end

  // FIFO bookkeeping; a write into a full FIFO is only legal alongside a read.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      OVF_OUT <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (state == S_DROP && vs_rise) OVF_OUT <= 1'b0;
      else if (ovf_evt)               OVF_OUT <= 1'b1;
    end
  end

  // NOTE: storage array has no reset; validity is carried entirely by count and the pointers.
  always_ff @(posedge CLK_IN) begin
    if (wr_en) mem[wr_ptr] <= wr_word;
  end

endmodule

// File: tb/tb_prt_scaler_vout.sv
// Directed bench for prt_scaler_vout: frame tagging, line count, overflow/drop,
// backpressure stability, mid-line reset and clock-enable qualification.
module tb_prt_scaler_vout;

  localparam int PPC   = 4;
  localparam int BPC   = 8;
  localparam int DEPTH = 16;
  localparam int DW    = 3 * PPC * BPC;

  logic              CLK_IN = 1'b0;
  logic              RST_IN = 1'b1;
  logic              CKE_IN = 1'b0;
  logic              VS_IN  = 1'b0;
  logic              HS_IN  = 1'b0;
  logic              DE_IN  = 1'b0;
  logic [PPC*BPC-1:0] R_IN  = '0;
  logic [PPC*BPC-1:0] G_IN  = '0;
  logic [PPC*BPC-1:0] B_IN  = '0;
  logic [DW-1:0]     M_DAT_OUT;
  logic              M_SOF_OUT;
  logic              M_EOL_OUT;
  logic              M_VLD_OUT;
  logic              M_RDY_IN = 1'b0;
  logic              OVF_OUT;
  logic [15:0]       LINES_OUT;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW+1:0] got_q[$];

  prt_scaler_vout #(.P_PPC(PPC), .P_BPC(BPC), .P_FIFO_DEPTH(DEPTH)) dut (
    .CLK_IN(CLK_IN), .RST_IN(RST_IN), .CKE_IN(CKE_IN),
    .VS_IN(VS_IN), .HS_IN(HS_IN), .DE_IN(DE_IN),
    .R_IN(R_IN), .G_IN(G_IN), .B_IN(B_IN),
    .M_DAT_OUT(M_DAT_OUT), .M_SOF_OUT(M_SOF_OUT), .M_EOL_OUT(M_EOL_OUT),
    .M_VLD_OUT(M_VLD_OUT), .M_RDY_IN(M_RDY_IN),
    .OVF_OUT(OVF_OUT), .LINES_OUT(LINES_OUT)
  );

  always #5 CLK_IN = ~CLK_IN;

  // Record every word that will be accepted at the coming rising edge.
  always @(negedge CLK_IN)
    if (M_VLD_OUT && M_RDY_IN) got_q.push_back({M_SOF_OUT, M_EOL_OUT, M_DAT_OUT});

  function automatic logic [DW-1:0] pix(input int k);
    logic [31:0] kk;
    kk = k;
    return {32'hA000_0000 | kk, 32'hB000_0000 | (kk << 4), ~kk};
  endfunction

  task automatic tick();
    @(posedge CLK_IN);
    #1;
  endtask

  // One qualified sample followed by period-1 unqualified cycles carrying garbage.
  task automatic qsample(input logic vs, input logic de, input int k, input int period);
    VS_IN  = vs;
    DE_IN  = de;
    HS_IN  = 1'($urandom_range(0, 1));
    {R_IN, G_IN, B_IN} = pix(k);
    CKE_IN = 1'b1;
    tick();
    CKE_IN = 1'b0;
    VS_IN  = ~vs;
    DE_IN  = ~de;
    R_IN   = ~R_IN;
    repeat (period - 1) tick();
  endtask

  task automatic send_vs(input int period);
    qsample(1'b1, 1'b0, 0, period);
    qsample(1'b0, 1'b0, 0, period);
  endtask

  task automatic send_line(input int base, input int n, input int period);
    for (int i = 0; i < n; i++) qsample(1'b0, 1'b1, base + i, period);
    qsample(1'b0, 1'b0, 0, period);
  endtask

  task automatic test_reset();
    RST_IN = 1'b1;
    tick();
    tick();
    n_cmp += 6;
    if (M_VLD_OUT !== 1'b0) begin n_err++; $display("FAIL reset_vld got=%b want=0", M_VLD_OUT); end
    if (M_SOF_OUT !== 1'b0) begin n_err++; $display("FAIL reset_sof got=%b want=0", M_SOF_OUT); end
    if (M_EOL_OUT !== 1'b0) begin n_err++; $display("FAIL reset_eol got=%b want=0", M_EOL_OUT); end
    if (M_DAT_OUT !== '0)   begin n_err++; $display("FAIL reset_dat got=%h want=0", M_DAT_OUT); end
    if (OVF_OUT !== 1'b0)   begin n_err++; $display("FAIL reset_ovf got=%b want=0", OVF_OUT); end
    if (LINES_OUT !== 16'd0) begin n_err++; $display("FAIL reset_lines got=%0d want=0", LINES_OUT); end
    RST_IN = 1'b0;
    tick();
  endtask

  task automatic test_basic_frame();
    logic [DW+1:0] exp;
    got_q.delete();
    M_RDY_IN = 1'b1;
    send_vs(4);
    send_line(0, 3, 4);
    send_line(3, 3, 4);
    repeat (10) tick();
    n_cmp++;
    if (got_q.size() != 6) begin n_err++; $display("FAIL basic_count got=%0d want=6", got_q.size()); end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      exp = {(i == 0), (i == 2 || i == 5), pix(i)};
      n_cmp++;
      if (got_q[i] !== exp) begin n_err++; $display("FAIL basic_word%0d got=%h want=%h", i, got_q[i], exp); end
    end
    n_cmp++;
    if (OVF_OUT !== 1'b0) begin n_err++; $display("FAIL basic_ovf got=%b want=0", OVF_OUT); end
  endtask

  task automatic test_line_count();
    qsample(1'b1, 1'b0, 0, 4);
    n_cmp++;
    if (LINES_OUT !== 16'd2) begin n_err++; $display("FAIL lines_out got=%0d want=2", LINES_OUT); end
    qsample(1'b0, 1'b0, 0, 4);
  endtask

  task automatic test_overflow();
    logic [DW+1:0] exp;
    got_q.delete();
    M_RDY_IN = 1'b0;
    send_line(100, DEPTH + 2, 1);
    repeat (3) tick();
    n_cmp += 2;
    if (OVF_OUT !== 1'b1)   begin n_err++; $display("FAIL ovf_set got=%b want=1", OVF_OUT); end
    if (M_VLD_OUT !== 1'b1) begin n_err++; $display("FAIL ovf_vld got=%b want=1", M_VLD_OUT); end
    M_RDY_IN = 1'b1;
    repeat (DEPTH + 8) tick();
    n_cmp++;
    if (got_q.size() != DEPTH) begin n_err++; $display("FAIL ovf_stored got=%0d want=%0d", got_q.size(), DEPTH); end
    for (int i = 0; i < DEPTH && i < got_q.size(); i++) begin
      exp = {(i == 0), 1'b0, pix(100 + i)};
      n_cmp++;
      if (got_q[i] !== exp) begin n_err++; $display("FAIL ovf_word%0d got=%h want=%h", i, got_q[i], exp); end
    end
    send_line(150, 3, 1);
    repeat (5) tick();
    n_cmp += 2;
    if (got_q.size() != DEPTH) begin n_err++; $display("FAIL drop_nowrite got=%0d want=%0d", got_q.size(), DEPTH); end
    if (OVF_OUT !== 1'b1)      begin n_err++; $display("FAIL drop_ovf_held got=%b want=1", OVF_OUT); end
    send_vs(1);
    n_cmp++;
    if (OVF_OUT !== 1'b0) begin n_err++; $display("FAIL ovf_clear got=%b want=0", OVF_OUT); end
    send_line(200, 2, 1);
    repeat (6) tick();
    n_cmp++;
    if (got_q.size() != DEPTH + 2) begin n_err++; $display("FAIL resume_count got=%0d want=%0d", got_q.size(), DEPTH + 2); end
    else begin
      n_cmp += 2;
      exp = {1'b1, 1'b0, pix(200)};
      if (got_q[DEPTH] !== exp) begin n_err++; $display("FAIL resume_sof_word got=%h want=%h", got_q[DEPTH], exp); end
      exp = {1'b0, 1'b1, pix(201)};
      if (got_q[DEPTH+1] !== exp) begin n_err++; $display("FAIL resume_eol_word got=%h want=%h", got_q[DEPTH+1], exp); end
    end
  endtask

  task automatic test_random_ready();
    logic [DW+1:0] exp, last, cur;
    logic last_stall, done;
    last_stall = 1'b0;
    last = '0;
    done = 1'b0;
    got_q.delete();
    fork
      begin
        send_vs(2);
        send_line(300, 8, 2);
        repeat (6) tick();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge CLK_IN);
          #1;
          M_RDY_IN = 1'($urandom_range(0, 1));
          @(negedge CLK_IN);
          cur = {M_SOF_OUT, M_EOL_OUT, M_DAT_OUT};
          if (last_stall) begin
            n_cmp++;
            if (!M_VLD_OUT || cur !== last) begin
              n_err++;
              $display("FAIL stall_stable got=%h vld=%b want=%h", cur, M_VLD_OUT, last);
            end
          end
          last_stall = M_VLD_OUT && !M_RDY_IN;
          last = cur;
        end
      end
    join
    M_RDY_IN = 1'b1;
    repeat (20) tick();
    n_cmp++;
    if (got_q.size() != 8) begin n_err++; $display("FAIL rand_count got=%0d want=8", got_q.size()); end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      exp = {(i == 0), (i == 7), pix(300 + i)};
      n_cmp++;
      if (got_q[i] !== exp) begin n_err++; $display("FAIL rand_word%0d got=%h want=%h", i, got_q[i], exp); end
    end
  endtask

  task automatic test_reset_midline();
    M_RDY_IN = 1'b0;
    send_vs(1);
    for (int i = 0; i < 6; i++) qsample(1'b0, 1'b1, 400 + i, 1);
    repeat (2) tick();
    n_cmp++;
    if (M_VLD_OUT !== 1'b1) begin n_err++; $display("FAIL midline_queued got=%b want=1", M_VLD_OUT); end
    RST_IN = 1'b1;
    tick();
    n_cmp++;
    if (M_VLD_OUT !== 1'b0) begin n_err++; $display("FAIL midline_flush got=%b want=0", M_VLD_OUT); end
    RST_IN = 1'b0;
    got_q.delete();
    M_RDY_IN = 1'b1;
    send_line(450, 3, 1);
    repeat (10) tick();
    n_cmp += 3;
    if (got_q.size() != 0)   begin n_err++; $display("FAIL idle_discard got=%0d want=0", got_q.size()); end
    if (M_VLD_OUT !== 1'b0)  begin n_err++; $display("FAIL idle_vld got=%b want=0", M_VLD_OUT); end
    if (LINES_OUT !== 16'd0) begin n_err++; $display("FAIL midline_lines got=%0d want=0", LINES_OUT); end
  endtask

  task automatic test_cke_off();
    logic [DW+1:0] exp;
    M_RDY_IN = 1'b1;
    send_vs(1);
    got_q.delete();
    for (int i = 0; i < 20; i++) begin
      CKE_IN = 1'b0;
      DE_IN  = 1'($urandom_range(0, 1));
      VS_IN  = 1'($urandom_range(0, 1));
      {R_IN, G_IN, B_IN} = pix(600 + i);
      tick();
    end
    VS_IN = 1'b0;
    repeat (4) tick();
    n_cmp++;
    if (got_q.size() != 0) begin n_err++; $display("FAIL cke_off_nowrite got=%0d want=0", got_q.size()); end
    send_line(500, 2, 1);
    repeat (8) tick();
    n_cmp++;
    if (got_q.size() != 2) begin n_err++; $display("FAIL cke_off_after got=%0d want=2", got_q.size()); end
    else begin
      n_cmp += 2;
      exp = {1'b1, 1'b0, pix(500)};
      if (got_q[0] !== exp) begin n_err++; $display("FAIL cke_off_word0 got=%h want=%h", got_q[0], exp); end
      exp = {1'b0, 1'b1, pix(501)};
      if (got_q[1] !== exp) begin n_err++; $display("FAIL cke_off_word1 got=%h want=%h", got_q[1], exp); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_line_count();
    test_overflow();
    test_random_ready();
    test_reset_midline();
    test_cke_off();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
